// File: rtl/controller_defs.sv
// Shared definitions for the data path controller: opcodes, FSM states,
// write-source selections and instruction field positions.
package controller_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_MEM_WAIT  = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ALU  = 4'd1;
    localparam logic [3:0] OP_LDI  = 4'd2;
    localparam logic [3:0] OP_LUI  = 4'd3;
    localparam logic [3:0] OP_LOAD = 4'd4;
    localparam logic [3:0] OP_HALT = 4'd5;

    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_IMM1 = 2'd1;
    localparam logic [1:0] SRC_IMM2 = 2'd2;
    localparam logic [1:0] SRC_MEM  = 2'd3;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 26;
    localparam int RS1_MSB = 25;
    localparam int RS1_LSB = 24;
    localparam int RS2_MSB = 23;
    localparam int RS2_LSB = 22;
    localparam int ALU_MSB = 21;
    localparam int ALU_LSB = 20;

endpackage

// File: rtl/instruction_decoder.sv
// Combinational decode of the instruction register into data path controls
// and the classification flags the sequencer branches on.
module instruction_decoder
    import controller_defs::*;
#(
    parameter int IMM_WIDTH = 20
) (
    input  logic [31:0] ir,
    output logic [1:0]  rd,
    output logic [1:0]  rs1,
    output logic [1:0]  rs2,
    output logic [1:0]  alu_op,
    output logic [31:0] imm1,
    output logic [31:0] imm2,
    output logic [1:0]  wsrc,
    output logic        is_load,
    output logic        is_halt,
    output logic        is_write,
    output logic        illegal
);

    logic [3:0]           opcode_s;
    logic [IMM_WIDTH-1:0] imm_s;

    assign opcode_s = ir[OPC_MSB:OPC_LSB];
    assign imm_s    = ir[IMM_WIDTH-1:0];
    assign rd       = ir[RD_MSB:RD_LSB];
    assign rs1      = ir[RS1_MSB:RS1_LSB];
    assign rs2      = ir[RS2_MSB:RS2_LSB];
    assign alu_op   = ir[ALU_MSB:ALU_LSB];
    assign imm1     = {{(32-IMM_WIDTH){imm_s[IMM_WIDTH-1]}}, imm_s};
    assign imm2     = {imm_s, {(32-IMM_WIDTH){1'b0}}};

    // Opcode classification; is_write covers the single-step register writes only
    always_comb begin
        wsrc     = SRC_ALU;
        is_load  = 1'b0;
        is_halt  = 1'b0;
        is_write = 1'b0;
        illegal  = 1'b0;
        case (opcode_s)
            OP_NOP:  wsrc = SRC_ALU;
            OP_ALU:  begin is_write = 1'b1; wsrc = SRC_ALU;  end
            OP_LDI:  begin is_write = 1'b1; wsrc = SRC_IMM1; end
            OP_LUI:  begin is_write = 1'b1; wsrc = SRC_IMM2; end
            OP_LOAD: begin is_load  = 1'b1; wsrc = SRC_MEM;  end
            OP_HALT: is_halt = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_path_controller.sv
// Multi-cycle sequencer for the 4-register data path: instruction handshake,
// decode, memory load with timeout, and a single-cycle register writeback.
module data_path_controller
    import controller_defs::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int IMM_WIDTH   = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    output logic                 mem_req,
    output logic [IMM_WIDTH-1:0] mem_addr,
    input  logic                 mem_ack,
    output logic [1:0]           input_register_selector_1,
    output logic [1:0]           input_register_selector_2,
    output logic [1:0]           output_register_selector,
    output logic [1:0]           output_source_selector,
    output logic                 output_enable,
    output logic [1:0]           alu_opcode,
    output logic [31:0]          ir_immediate_1,
    output logic [31:0]          ir_immediate_2,
    output logic                 busy,
    output logic                 halted,
    output logic                 error
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_r;
    logic [31:0] ir_r;
    logic [7:0]  wait_cnt_r;
    logic        instr_ready_r;
    logic        mem_req_r;
    logic        output_enable_r;
    logic [1:0]  src_r;
    logic        busy_r;
    logic        halted_r;
    logic        error_r;

    logic [1:0]  wsrc_s;
    logic        is_load_s;
    logic        is_halt_s;
    logic        is_write_s;
    logic        illegal_s;

    instruction_decoder #(.IMM_WIDTH(IMM_WIDTH)) u_decoder (
        .ir       (ir_r),
        .rd       (output_register_selector),
        .rs1      (input_register_selector_1),
        .rs2      (input_register_selector_2),
        .alu_op   (alu_opcode),
        .imm1     (ir_immediate_1),
        .imm2     (ir_immediate_2),
        .wsrc     (wsrc_s),
        .is_load  (is_load_s),
        .is_halt  (is_halt_s),
        .is_write (is_write_s),
        .illegal  (illegal_s)
    );

    assign mem_addr               = ir_r[IMM_WIDTH-1:0];
    assign instr_ready            = instr_ready_r;
    assign mem_req                = mem_req_r;
    assign output_enable          = output_enable_r;
    assign output_source_selector = src_r;
    assign busy                   = busy_r;
    assign halted                 = halted_r;
    assign error                  = error_r;

    // Sequencer FSM; outputs are set on the transition into the state they belong to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            ir_r            <= 32'h0000_0000;
            wait_cnt_r      <= 8'd0;
            instr_ready_r   <= 1'b0;
            mem_req_r       <= 1'b0;
            output_enable_r <= 1'b0;
            src_r           <= SRC_ALU;
            busy_r          <= 1'b0;
            halted_r        <= 1'b0;
            error_r         <= 1'b0;
        end else begin
            output_enable_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (instr_valid && instr_ready_r) begin
                        ir_r          <= instr;
                        instr_ready_r <= 1'b0;
                        busy_r        <= 1'b1;
                        state_r       <= ST_DECODE;
                    end else begin
                        instr_ready_r <= !halted_r && !error_r;
                        busy_r        <= halted_r;
                    end
                end
                ST_DECODE: begin
                    if (illegal_s) begin
                        error_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (is_halt_s) begin
                        halted_r <= 1'b1;
                        state_r  <= ST_HALT;
                    end else if (is_load_s) begin
                        mem_req_r  <= 1'b1;
                        wait_cnt_r <= 8'd0;
                        state_r    <= ST_MEM_WAIT;
                    end else if (is_write_s) begin
                        output_enable_r <= 1'b1;
                        src_r           <= wsrc_s;
                        state_r         <= ST_WRITEBACK;
                    end else begin
                        instr_ready_r <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= ST_IDLE;
                    end
                end
                ST_MEM_WAIT: begin
                    // An ack arriving in the final allowed cycle still completes the load
                    if (mem_ack) begin
                        mem_req_r       <= 1'b0;
                        output_enable_r <= 1'b1;
                        src_r           <= wsrc_s;
                        state_r         <= ST_WRITEBACK;
                    end else if (wait_cnt_r == TIMEOUT_LAST) begin
                        mem_req_r <= 1'b0;
                        error_r   <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                ST_WRITEBACK: begin
                    instr_ready_r <= 1'b1;
                    busy_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                ST_HALT: begin
                    instr_ready_r <= 1'b0;
                    state_r       <= ST_HALT;
                end
                default: begin
                    instr_ready_r <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_path_controller.sv
// Self-checking bench for data_path_controller: directed vector table, a
// mid-load reset sequence and randomized instructions against a trace model.
module tb_data_path_controller;

    localparam int TO = 15;
    localparam int W  = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack;
    logic [1:0]  sel1, sel2, seld, src;
    logic        output_enable;
    logic [1:0]  alu_opcode;
    logic [31:0] imm1, imm2;
    logic        busy, halted, error;

    always #5 clk = ~clk;

    data_path_controller #(.MEM_TIMEOUT(TO), .IMM_WIDTH(20)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .instr                     (instr),
        .instr_valid               (instr_valid),
        .instr_ready               (instr_ready),
        .mem_req                   (mem_req),
        .mem_addr                  (mem_addr),
        .mem_ack                   (mem_ack),
        .input_register_selector_1 (sel1),
        .input_register_selector_2 (sel2),
        .output_register_selector  (seld),
        .output_source_selector    (src),
        .output_enable             (output_enable),
        .alu_opcode                (alu_opcode),
        .ir_immediate_1            (imm1),
        .ir_immediate_2            (imm2),
        .busy                      (busy),
        .halted                    (halted),
        .error                     (error)
    );

    // Expected trace of one instruction, cycles counted from the accept edge
    typedef struct {
        logic [31:0] instr;
        int          k;
        bit          hold_v;
        bit          hold_ack;
        int          writes;
        int          wcyc;
        int          src;
        int          rdy;
        int          mreq;
        bit          err;
        bit          hlt;
    } vec_t;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [31:0] ins, input int k, input bit hv, input bit ha);
        vec_t v;
        int   op;
        v.instr = ins; v.k = k; v.hold_v = hv; v.hold_ack = ha;
        v.writes = 0; v.wcyc = -1; v.src = -1; v.rdy = -1; v.mreq = 0; v.err = 1'b0; v.hlt = 1'b0;
        op = int'(ins[31:28]);
        case (op)
            0: v.rdy = 2;
            1, 2, 3: begin v.writes = 1; v.wcyc = 2; v.src = op - 1; v.rdy = 3; end
            4: begin
                if (k < TO) begin
                    v.writes = 1; v.wcyc = 3 + k; v.src = 3; v.rdy = 4 + k; v.mreq = k + 1;
                end else begin
                    v.mreq = TO; v.err = 1'b1;
                end
            end
            5: v.hlt = 1'b1;
            default: v.err = 1'b1;
        endcase
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input vec_t v, input string tag);
        int          n = 0;
        int          writes = 0, wcyc = -1, wsrc = -1, rdy = -1, mreq = 0;
        logic [1:0]  c_s1, c_s2, c_sd, c_alu;
        logic [31:0] c_i1, c_i2;
        logic [19:0] c_addr, imm;
        logic        c_busy;
        logic [31:0] e1, e2;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready_in"}, {31'd0, instr_ready}, 32'd1);
        instr       = v.instr;
        instr_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= W; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (!v.hold_v) instr_valid = 1'b0;
                c_s1 = sel1; c_s2 = sel2; c_sd = seld; c_alu = alu_opcode;
                c_i1 = imm1; c_i2 = imm2; c_addr = mem_addr; c_busy = busy;
            end
            if (output_enable) begin
                writes++;
                if (wcyc < 0) begin wcyc = c; wsrc = int'(src); end
            end
            if (mem_req) mreq++;
            if (instr_ready && rdy < 0) rdy = c;
            mem_ack = (c == 2 + v.k) || (v.hold_ack && c >= 2 + v.k);
        end
        mem_ack     = 1'b0;
        instr_valid = 1'b0;
        imm = v.instr[19:0];
        e1  = {12'h000, imm} - (imm[19] ? 32'h0010_0000 : 32'h0000_0000);
        e2  = {12'h000, imm} * 32'd4096;
        chk({tag, ".writes"}, writes, v.writes);
        chk({tag, ".wcyc"}, wcyc, v.wcyc);
        if (v.writes > 0) chk({tag, ".src"}, wsrc, v.src);
        chk({tag, ".rdy"}, rdy, v.rdy);
        chk({tag, ".mreq"}, mreq, v.mreq);
        chk({tag, ".error"}, {31'd0, error}, {31'd0, v.err});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, v.hlt});
        chk({tag, ".busy_end"}, {31'd0, busy}, {31'd0, v.hlt});
        chk({tag, ".busy_dec"}, {31'd0, c_busy}, 32'd1);
        chk({tag, ".sel"}, {24'd0, c_sd, c_s1, c_s2, c_alu},
            {24'd0, v.instr[27:26], v.instr[25:24], v.instr[23:22], v.instr[21:20]});
        chk({tag, ".imm1"}, c_i1, e1);
        chk({tag, ".imm2"}, c_i2, e2);
        chk({tag, ".addr"}, {12'd0, c_addr}, {12'd0, imm});
        if (v.err || v.hlt) do_reset();
    endtask

    vec_t tbl[11];

    initial begin
        reset       = 1'b1;
        instr       = 32'h0000_0000;
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.outs", {24'd0, instr_ready, mem_req, output_enable, busy, halted, error, src},
            32'd0);
        chk("rst.imm", imm1 | imm2 | {12'd0, mem_addr} | {24'd0, sel1, sel2, seld, alu_opcode},
            32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.ready", {31'd0, instr_ready}, 32'd1);

        tbl[0]  = '{32'h1_D_80000 | {4'd1, 2'd3, 2'd1, 2'd2, 2'd2, 20'h0}, 0, 1'b0, 1'b0, 1, 2, 0, 3, 0, 1'b0, 1'b0};
        tbl[0].instr = {4'd1, 2'd3, 2'd1, 2'd2, 2'd2, 20'h00000};
        tbl[1]  = '{{4'd2, 2'd1, 2'd0, 2'd0, 2'd0, 20'hFFFFE}, 0, 1'b0, 1'b0, 1, 2, 1, 3, 0, 1'b0, 1'b0};
        tbl[2]  = '{{4'd3, 2'd2, 2'd3, 2'd1, 2'd1, 20'h00001}, 0, 1'b0, 1'b0, 1, 2, 2, 3, 0, 1'b0, 1'b0};
        tbl[3]  = '{{4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 20'h12345}, 0, 1'b0, 1'b0, 0, -1, -1, 2, 0, 1'b0, 1'b0};
        tbl[4]  = '{{4'd4, 2'd2, 2'd0, 2'd0, 2'd0, 20'h00040}, 3, 1'b0, 1'b1, 1, 6, 3, 7, 4, 1'b0, 1'b0};
        tbl[5]  = '{{4'd4, 2'd1, 2'd0, 2'd0, 2'd0, 20'h80000}, 0, 1'b0, 1'b0, 1, 3, 3, 4, 1, 1'b0, 1'b0};
        tbl[6]  = '{{4'd4, 2'd3, 2'd0, 2'd0, 2'd0, 20'h00F00}, 14, 1'b0, 1'b0, 1, 17, 3, 18, 15, 1'b0, 1'b0};
        tbl[7]  = '{{4'd4, 2'd0, 2'd0, 2'd0, 2'd0, 20'h00010}, 99, 1'b0, 1'b0, 0, -1, -1, -1, 15, 1'b1, 1'b0};
        tbl[8]  = '{{4'd5, 2'd0, 2'd0, 2'd0, 2'd0, 20'h00000}, 0, 1'b1, 1'b0, 0, -1, -1, -1, 0, 1'b0, 1'b1};
        tbl[9]  = '{{4'd7, 2'd3, 2'd0, 2'd0, 2'd0, 20'h00000}, 0, 1'b1, 1'b0, 0, -1, -1, -1, 0, 1'b1, 1'b0};
        tbl[10] = '{{4'd15, 2'd1, 2'd2, 2'd3, 2'd0, 20'h7FFFF}, 0, 1'b0, 1'b0, 0, -1, -1, -1, 0, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) run(tbl[i], $sformatf("tbl%0d", i));

        // Reset in the middle of a load must drop mem_req without waiting for a clock
        while (!instr_ready) @(negedge clk);
        instr       = {4'd4, 2'd1, 2'd0, 2'd0, 2'd0, 20'h00040};
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst.req_before", {31'd0, mem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst.async", {28'd0, mem_req, output_enable, busy, instr_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst.ready", {30'd0, instr_ready, error}, 32'd2);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] r;
            logic [3:0]  op;
            int          k;
            r  = $urandom();
            op = 4'($urandom_range(0, 8));
            if (op > 4'd5) op = 4'($urandom_range(6, 15));
            k  = $urandom_range(0, 17);
            run(model({op, r[27:0]}, k, 1'b0, 1'b0), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_path_controller.md
Name: data_path_controller

Overview:
Multi-cycle sequencer for the 4-register, 32-bit data path. It accepts 32-bit instruction words over a valid/ready handshake and decodes them. It then drives the data path's register selectors, write-source mux, write enable, ALU opcode and both immediate buses. LOAD instructions run a request/acknowledge handshake with data memory, which is guarded by a timeout.

Parameters:
MEM_TIMEOUT, 15, maximum cycles spent in MEM_WAIT before the controller aborts with an error (legal range 1..255)
IMM_WIDTH, 20, width of the instruction immediate field

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
instr  input  32  instruction word: [31:28] opcode, [27:26] rd, [25:24] rs1, [23:22] rs2, [21:20] alu_op, [19:0] imm
instr_valid  input  1  instr is presented
instr_ready  output  1  controller accepts instr this cycle
mem_req  output  1  data memory read request
mem_addr  output  20  read address, equal to imm
mem_ack  input  1  memory data is valid on the data path's memory input this cycle
input_register_selector_1  output  2  rs1
input_register_selector_2  output  2  rs2
output_register_selector  output  2  rd
output_source_selector  output  2  0=ALU, 1=imm1, 2=imm2, 3=memory
output_enable  output  1  register file write strobe
alu_opcode  output  2  ALU operation
ir_immediate_1  output  32  sign-extended imm
ir_immediate_2  output  32  {imm, 12'b0} (upper immediate)
busy  output  1  state is not IDLE
halted  output  1  HALT has executed (sticky)
error  output  1  illegal opcode or memory timeout (sticky)

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0, instruction register cleared, halted=0, error=0.
- Opcodes: 0 NOP, 1 ALU, 2 LDI, 3 LUI, 4 LOAD, 5 HALT; 6..15 are illegal.
- States: IDLE, DECODE, MEM_WAIT, WRITEBACK, HALT.
- IDLE:
  - instr_ready = !halted && !error.
  - When instr_valid && instr_ready, latch instr into IR and go to DECODE.
- DECODE:
  - Selectors, alu_opcode and immediates come from IR and stay registered-stable until the next accept.
  - NOP: go to IDLE.
  - ALU / LDI / LUI: go to WRITEBACK.
  - LOAD: assert mem_req and go to MEM_WAIT.
  - HALT: set halted and go to HALT.
  - Illegal opcode: set error and go to IDLE; no write occurs.
- MEM_WAIT:
  - mem_req stays high until mem_ack is seen.
  - On mem_ack: drop mem_req and go to WRITEBACK.
  - The wait counter increments each cycle without ack. When the count reaches MEM_TIMEOUT: set error, drop mem_req, go to IDLE, no write.
  - mem_ack in the same cycle as the timeout: ack wins.
- WRITEBACK:
  - output_enable=1 for exactly one cycle.
  - output_source_selector = 0 (ALU), 1 (LDI), 2 (LUI) or 3 (LOAD).
  - Go to IDLE.
- output_enable is 0 in every other state; output_source_selector holds its last value.
- Latency (accept at cycle t):
  - ALU/LDI/LUI: write strobe at t+2, instr_ready at t+3.
  - LOAD with ack k cycles after entering MEM_WAIT (k ≥ 0): write strobe at t+3+k.
  - NOP: instr_ready at t+2.
- Handshake rules:
  - instr_ready=0 in every non-IDLE state.
  - instr_valid may be held indefinitely.
  - mem_ack outside MEM_WAIT is ignored.
- HALT and error are terminal: only reset leaves them.
- busy = (state != IDLE) || halted.
- Reset mid-operation aborts immediately: mem_req and output_enable drop asynchronously.
- imm arithmetic:
  - imm1 = {{12{imm[19]}}, imm}.
  - imm2 = {imm, 12'h000}.
  - No overflow handling is needed.

Decomposition:
- Shared package/include (controller_defs): opcode constants, state encodings, source-select constants (SRC_ALU, SRC_IMM1, SRC_IMM2, SRC_MEM), and instruction field bit positions.
- One sub-module, instruction_decoder: combinational. Maps the IR to selectors, alu_opcode, immediates, write source, and the is_load / is_halt / is_write / illegal flags.
- The FSM, timeout counter and handshake logic stay in data_path_controller.
- Top level instantiates data_path_controller alongside data_path.

Test Plan:
- Reset mid-LOAD with mem_req=1 -> mem_req=0 asynchronously, state IDLE, instr_ready=1 after reset release.
- ALU instr opcode=1, rd=3, rs1=1, rs2=2, alu_op=2 accepted at t -> output_enable=1 only at t+2 with source=0, selectors 3/1/2, alu_opcode=2; instr_ready=1 at t+3.
- LDI imm=20'hFFFFE, then LUI imm=20'h00001 -> ir_immediate_1=32'hFFFFFFFE with source=1; ir_immediate_2=32'h00001000 with source=2.
- LOAD imm=20'h00040, mem_ack after 3 cycles -> mem_addr=20'h00040; mem_req high for 4 cycles; single write strobe with source=3; no second write if ack stays high.
- LOAD with no ack, MEM_TIMEOUT=15 -> error=1 after 15 MEM_WAIT cycles; no write; instr_ready stays 0 afterward.
- HALT, then opcode 7 on a fresh reset -> halted=1 with instr_ready=0 while instr_valid is held; illegal opcode sets error=1 with no output_enable pulse.
